rect_receive_buffer: RTL and testbench
======================================

Name: rect_receive_buffer

Overview:
- GPU-side stage directly downstream of the DMA rect copy controller.
- Consumes the gap-free word stream the DMA emits after copy_start: 64 packets of 6 words (marker, abs_x, abs_y, width, height, color).
- Deserializes each packet into a bounding-box entry and writes it to a double-buffered rect table.
- Exposes a registered read port to the rasterizer; banks swap atomically when a full copy completes.

Parameters:
- COORD_WIDTH, 16, coordinate/size field width
- RECT_COUNT, 64, rects per copy
- IDX_WIDTH, 6, rect index width (log2 RECT_COUNT)
- WORDS_PER_RECT, 6, stream words per packet

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- copy_start  in  1  same signal driven to the DMA; stream begins next cycle
- stream_din  in  16  DMA mem_dout word
- rd_idx  in  IDX_WIDTH  rasterizer read index into the front bank
- rd_x0  out  COORD_WIDTH  left edge, registered
- rd_y0  out  COORD_WIDTH  top edge, registered
- rd_x1  out  COORD_WIDTH  right edge, exclusive, saturated, registered
- rd_y1  out  COORD_WIDTH  bottom edge, exclusive, saturated, registered
- rd_color  out  16  fill color, registered
- front_valid  out  1  front bank holds a complete frame
- busy  out  1  copy in progress
- copy_done  out  1  one-cycle pulse on bank swap

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, field_cnt=0, rect_cnt=0, front_sel=0, both bank-valid flags=0.
  - All rd_* outputs=0, busy=0, copy_done=0.
  - Table contents are not reset.
- States are IDLE and RECEIVE.
- IDLE:
  - copy_start=1 moves to RECEIVE next cycle; busy=1 from that cycle.
  - Clears field_cnt and rect_cnt.
- RECEIVE: one word is accepted every cycle, with no stall and no valid strobe. field_cnt cycles 0..5.
  - field 0 (marker): ignored.
  - field 1: latch x; field 2: latch y; field 3: latch w; field 4: latch h.
  - field 5: the color word is used directly. Write entry {x0=x, y0=y, x1=sat(x+w), y1=sat(y+h), color} to the back bank (index !front_sel) at rect_cnt, then rect_cnt+1.
- Saturation: sums are computed at COORD_WIDTH+1 bits. If the carry is set, the result is 2^COORD_WIDTH-1.
- After the field-5 write with rect_cnt==RECT_COUNT-1, on the next edge:
  - front_sel toggles and the new front bank's valid flag is set.
  - copy_done pulses for that cycle; state returns to IDLE and busy drops.
  - Total time is exactly 6*RECT_COUNT cycles from the first stream word to the swap edge.
- copy_start while in RECEIVE is ignored.
- A copy_start on the swap cycle itself is also ignored; it is sampled only in IDLE.
- Read port:
  - rd_* registers the front-bank entry at rd_idx, giving 1-cycle latency.
  - If the front bank is not valid, rd_* registers 0.
  - A read on the swap edge returns the old front bank. The next read sees the new bank.
- Writes never target the front bank, so there is no read/write hazard.
- Reset mid-copy: the partial back bank is discarded (valid stays 0), front_sel is 0, and no copy_done is produced.
- Indices wrap naturally; rect_cnt never exceeds RECT_COUNT-1 while in RECEIVE.

Decomposition:
- Shared package (gpu_pkg) holds:
  - rect_entry_t struct {x0, y0, x1, y1, color}.
  - Localparams RECT_COUNT and WORDS_PER_RECT, plus field index constants FIELD_MARK..FIELD_COLOR.
  - State enum {IDLE, RECEIVE}.
- One sub-module, rect_table_bank: RECT_COUNT x rect_entry_t storage with one sync write port and one registered read port. It is instantiated twice; the output mux is selected by front_sel.
- The deserializer FSM and saturating adders stay in the top module.

Test Plan:
- Reset, then read rd_idx=5 -> front_valid=0, all rd_*=0; busy=0.
- copy_start, then stream rect 0 = {0,10,20,30,40,0xF00F} and rects 1..63 = {0,i,i,1,1,i} -> copy_done pulses exactly 384 cycles after the first word; front_valid=1. rd_idx=0 one cycle later gives x0=10, y0=20, x1=40, y1=60, color=0xF00F. rd_idx=63 gives 63,63,64,64,63.
- Rect with x=0xFFF0, w=0x0020, y=5, h=0 -> x1=0xFFFF (saturated), y1=5.
- Second copy with all colors=0xAAAA while holding rd_idx=0 -> reads return 0xF00F until the swap edge, then 0xAAAA from the following cycle; the copy_start pulse mid-copy has no effect.
- Assert reset at cycle 100 of a copy -> busy=0 and front_valid=0 immediately (asynchronous); no copy_done; a subsequent full copy completes normally.
- copy_start held high continuously -> copies run back-to-back with one IDLE cycle between them; copy_done pulses every 385 cycles; front_sel alternates.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU-side rect receive path.
// Holds the rect table entry layout, the stream packet geometry and
// field positions, the deserializer state encoding and the saturating
// edge adder used when building an entry.
package gpu_pkg;

    localparam int COORD_WIDTH    = 16;
    localparam int RECT_COUNT     = 64;
    localparam int IDX_WIDTH      = 6;
    localparam int WORDS_PER_RECT = 6;

    localparam logic [2:0] FIELD_MARK  = 3'd0;
    localparam logic [2:0] FIELD_X     = 3'd1;
    localparam logic [2:0] FIELD_Y     = 3'd2;
    localparam logic [2:0] FIELD_W     = 3'd3;
    localparam logic [2:0] FIELD_H     = 3'd4;
    localparam logic [2:0] FIELD_COLOR = 3'd5;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x0;
        logic [COORD_WIDTH-1:0] y0;
        logic [COORD_WIDTH-1:0] x1;
        logic [COORD_WIDTH-1:0] y1;
        logic [15:0]            color;
    } rect_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    // Exclusive right/bottom edge; clamps to the largest coordinate when
    // origin + size does not fit.
    function automatic logic [COORD_WIDTH-1:0] sat_add(
        input logic [COORD_WIDTH-1:0] a,
        input logic [COORD_WIDTH-1:0] b
    );
        logic [COORD_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_WIDTH] ? {COORD_WIDTH{1'b1}} : sum[COORD_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rect_table_bank.sv
// One bank of the double-buffered rect table.
// Ports:
//   clk        system clock
//   i_wr_en    write strobe
//   i_wr_idx   write index
//   i_wr_data  entry to store
//   i_rd_idx   read index
//   o_rd_data  entry at i_rd_idx, registered (1-cycle latency)
// Storage and read register are intentionally not reset; the consumer
// qualifies the read data with the bank-valid state.
module rect_table_bank
    import gpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [IDX_WIDTH-1:0] i_wr_idx,
    input  rect_entry_t          i_wr_data,
    input  logic [IDX_WIDTH-1:0] i_rd_idx,
    output rect_entry_t          o_rd_data
);

    rect_entry_t r_mem [RECT_COUNT];
    rect_entry_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rect_receive_buffer.sv
// Deserializes the DMA rect stream into a double-buffered rect table and
// serves the rasterizer from the front bank.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   copy_start   copy request; stream words follow from the next cycle
//   stream_din   stream word, one per cycle while receiving
//   rd_idx       rasterizer read index into the front bank
//   rd_x0/rd_y0  left/top edge (registered)
//   rd_x1/rd_y1  right/bottom edge, exclusive, saturated (registered)
//   rd_color     fill color (registered)
//   front_valid  front bank holds a complete frame
//   busy         copy in progress
//   copy_done    one-cycle pulse after the bank swap
//
// state   | meaning
// IDLE    | waiting for copy_start; counters held at zero
// RECEIVE | accepting one stream word per cycle into the back bank
module rect_receive_buffer
    import gpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   copy_start,
    input  logic [15:0]            stream_din,
    input  logic [IDX_WIDTH-1:0]   rd_idx,
    output logic [COORD_WIDTH-1:0] rd_x0,
    output logic [COORD_WIDTH-1:0] rd_y0,
    output logic [COORD_WIDTH-1:0] rd_x1,
    output logic [COORD_WIDTH-1:0] rd_y1,
    output logic [15:0]            rd_color,
    output logic                   front_valid,
    output logic                   busy,
    output logic                   copy_done
);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [2:0]             r_field_cnt;
    logic [IDX_WIDTH-1:0]   r_rect_cnt;
    logic [COORD_WIDTH-1:0] r_x;
    logic [COORD_WIDTH-1:0] r_y;
    logic [COORD_WIDTH-1:0] r_w;
    logic [COORD_WIDTH-1:0] r_h;
    logic                   r_front_sel;
    logic [1:0]             r_bank_valid;
    logic                   r_copy_done;
    logic                   r_rd_valid;
    logic                   r_rd_sel;

    logic        w_accept;
    logic        w_write;
    logic        w_swap;
    rect_entry_t w_wr_entry;
    rect_entry_t w_rd0;
    rect_entry_t w_rd1;
    rect_entry_t w_rd_entry;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (copy_start) begin
                    w_state_nxt = RECEIVE;
                end
            end
            RECEIVE: begin
                w_accept = 1'b1;
                if (r_field_cnt == FIELD_COLOR) begin
                    w_write = 1'b1;
                    // The last entry write and the bank swap share one edge,
                    // so the new front bank is complete the moment it flips.
                    if (r_rect_cnt == IDX_WIDTH'(RECT_COUNT - 1)) begin
                        w_swap      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_field_cnt <= FIELD_MARK;
            r_rect_cnt  <= '0;
        end else if (r_state == IDLE) begin
            r_field_cnt <= FIELD_MARK;
            r_rect_cnt  <= '0;
        end else if (r_field_cnt == FIELD_COLOR) begin
            r_field_cnt <= FIELD_MARK;
            r_rect_cnt  <= r_rect_cnt + 1'b1;
        end else begin
            r_field_cnt <= r_field_cnt + 3'd1;
        end
    end

    // Geometry holding registers; only meaningful within a packet.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (r_field_cnt)
                FIELD_X: r_x <= stream_din;
                FIELD_Y: r_y <= stream_din;
                FIELD_W: r_w <= stream_din;
                FIELD_H: r_h <= stream_din;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wr_entry.x0    = r_x;
        w_wr_entry.y0    = r_y;
        w_wr_entry.x1    = sat_add(r_x, r_w);
        w_wr_entry.y1    = sat_add(r_y, r_h);
        w_wr_entry.color = stream_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front_sel  <= 1'b0;
            r_bank_valid <= 2'b00;
            r_copy_done  <= 1'b0;
        end else begin
            r_copy_done <= w_swap;
            if (w_swap) begin
                r_front_sel               <= !r_front_sel;
                r_bank_valid[!r_front_sel] <= 1'b1;
            end
        end
    end

    // Bank select and valid are captured with the read address so a read
    // issued on the swap edge still resolves against the old front bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_rd_valid <= front_valid;
            r_rd_sel   <= r_front_sel;
        end
    end

    rect_table_bank u_bank0 (
        .clk       (clk),
        .i_wr_en   (w_write && r_front_sel),
        .i_wr_idx  (r_rect_cnt),
        .i_wr_data (w_wr_entry),
        .i_rd_idx  (rd_idx),
        .o_rd_data (w_rd0)
    );

    rect_table_bank u_bank1 (
        .clk       (clk),
        .i_wr_en   (w_write && !r_front_sel),
        .i_wr_idx  (r_rect_cnt),
        .i_wr_data (w_wr_entry),
        .i_rd_idx  (rd_idx),
        .o_rd_data (w_rd1)
    );

    assign w_rd_entry = r_rd_sel ? w_rd1 : w_rd0;

    assign rd_x0       = r_rd_valid ? w_rd_entry.x0    : '0;
    assign rd_y0       = r_rd_valid ? w_rd_entry.y0    : '0;
    assign rd_x1       = r_rd_valid ? w_rd_entry.x1    : '0;
    assign rd_y1       = r_rd_valid ? w_rd_entry.y1    : '0;
    assign rd_color    = r_rd_valid ? w_rd_entry.color : '0;
    assign front_valid = r_bank_valid[r_front_sel];
    assign busy        = (r_state == RECEIVE);
    assign copy_done   = r_copy_done;

endmodule

// File: tb/tb_rect_receive_buffer.sv
module tb_rect_receive_buffer;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        copy_start;
    logic [15:0] stream_din;
    logic [5:0]  rd_idx;
    logic [15:0] rd_x0, rd_y0, rd_x1, rd_y1, rd_color;
    logic        front_valid, busy, copy_done;

    always #5 clk = ~clk;

    rect_receive_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .copy_start  (copy_start),
        .stream_din  (stream_din),
        .rd_idx      (rd_idx),
        .rd_x0       (rd_x0),
        .rd_y0       (rd_y0),
        .rd_x1       (rd_x1),
        .rd_y1       (rd_y1),
        .rd_color    (rd_color),
        .front_valid (front_valid),
        .busy        (busy),
        .copy_done   (copy_done)
    );

    typedef struct {
        logic [15:0] x0, y0, x1, y1, color;
        logic        fv, busy, done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: two tables of whole rects, a front index, and a
    // word count for the copy in flight.
    logic [15:0] t_x0 [2][64];
    logic [15:0] t_y0 [2][64];
    logic [15:0] t_x1 [2][64];
    logic [15:0] t_y1 [2][64];
    logic [15:0] t_col[2][64];
    logic [15:0] cur  [6];
    bit          m_valid[2];
    int          m_front;
    bit          m_busy;
    int          m_words;

    logic [15:0] pkt[384];

    bit b2b = 1'b0;
    int last_done = -1;
    int n_cycles = 0;

    function void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function void model_reset();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_front    = 0;
        m_busy     = 1'b0;
        m_words    = 0;
    endfunction

    function logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // Advance the model across one clock edge with the given inputs and
    // return what the DUT must show after that edge.
    function void model_edge(input bit cs, input logic [15:0] din,
                             input logic [5:0] idx, output exp_t e);
        int r;
        int b;
        e.x0 = 16'h0; e.y0 = 16'h0; e.x1 = 16'h0; e.y1 = 16'h0; e.color = 16'h0;
        if (m_valid[m_front]) begin
            e.x0    = t_x0[m_front][idx];
            e.y0    = t_y0[m_front][idx];
            e.x1    = t_x1[m_front][idx];
            e.y1    = t_y1[m_front][idx];
            e.color = t_col[m_front][idx];
        end
        e.done = 1'b0;
        if (!m_busy) begin
            if (cs) begin
                m_busy  = 1'b1;
                m_words = 0;
            end
        end else begin
            cur[m_words % 6] = din;
            if (m_words % 6 == 5) begin
                r = m_words / 6;
                b = 1 - m_front;
                t_x0[b][r]  = cur[1];
                t_y0[b][r]  = cur[2];
                t_x1[b][r]  = sat16(cur[1], cur[3]);
                t_y1[b][r]  = sat16(cur[2], cur[4]);
                t_col[b][r] = cur[5];
            end
            m_words++;
            if (m_words == 6 * 64) begin
                m_front          = 1 - m_front;
                m_valid[m_front] = 1'b1;
                m_busy           = 1'b0;
                e.done           = 1'b1;
            end
        end
        e.fv   = m_valid[m_front];
        e.busy = m_busy;
    endfunction

    task automatic cyc(input bit cs, input logic [15:0] din, input logic [5:0] idx);
        exp_t e;
        copy_start = cs;
        stream_din = din;
        rd_idx     = idx;
        model_edge(cs, din, idx, e);
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        n_cycles++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rd_x0", rd_x0, e.x0);
            chk("rd_y0", rd_y0, e.y0);
            chk("rd_x1", rd_x1, e.x1);
            chk("rd_y1", rd_y1, e.y1);
            chk("rd_color", rd_color, e.color);
            chk("front_valid", front_valid, e.fv);
            chk("busy", busy, e.busy);
            chk("copy_done", copy_done, e.done);
        end
        if (b2b && copy_done === 1'b1) begin
            if (last_done >= 0) chk("done_spacing", n_cycles - last_done, 385);
            last_done = n_cycles;
        end
    end

    function logic [5:0] pick_idx(input bit zero);
        return zero ? 6'd0 : 6'($urandom);
    endfunction

    task automatic fill_random(input bit fix_color);
        for (int r = 0; r < 64; r++) begin
            for (int f = 0; f < 6; f++) pkt[6*r+f] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                pkt[6*r+3] = 16'($urandom_range(0, 255));
                pkt[6*r+4] = 16'($urandom_range(0, 255));
            end
            if (fix_color) pkt[6*r+5] = 16'hAAAA;
        end
    endtask

    task automatic reset_mid();
        #1;
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_front_valid", front_valid, 1'b0);
        chk("rst_copy_done", copy_done, 1'b0);
        chk("rst_rd_color", rd_color, 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_copy(input bit rd_zero, input int mid_start,
                            input bit swap_start, input int rst_at);
        cyc(1'b1, 16'h0, pick_idx(rd_zero));
        for (int k = 0; k < 384; k++) begin
            if (k == rst_at) begin
                reset_mid();
                return;
            end
            cyc((k == mid_start) || (swap_start && k == 383), pkt[k], pick_idx(rd_zero));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset      = 1'b1;
        copy_start = 1'b0;
        stream_din = 16'h0;
        rd_idx     = 6'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (4) cyc(1'b0, 16'($urandom), 6'd5);

        // Copy 1: directed contents.
        pkt[0] = 16'h0; pkt[1] = 16'd10; pkt[2] = 16'd20;
        pkt[3] = 16'd30; pkt[4] = 16'd40; pkt[5] = 16'hF00F;
        for (int r = 1; r < 64; r++) begin
            pkt[6*r]   = 16'h0;
            pkt[6*r+1] = 16'(r);
            pkt[6*r+2] = 16'(r);
            pkt[6*r+3] = 16'd1;
            pkt[6*r+4] = 16'd1;
            pkt[6*r+5] = 16'(r);
        end
        run_copy(1'b0, -1, 1'b0, -1);

        cyc(1'b0, 16'h0, 6'd0);
        @(negedge clk);
        chk("c1_idx0_x0", rd_x0, 16'd10);
        chk("c1_idx0_y0", rd_y0, 16'd20);
        chk("c1_idx0_x1", rd_x1, 16'd40);
        chk("c1_idx0_y1", rd_y1, 16'd60);
        chk("c1_idx0_color", rd_color, 16'hF00F);
        cyc(1'b0, 16'h0, 6'd63);
        @(negedge clk);
        chk("c1_idx63_x1", rd_x1, 16'd64);
        chk("c1_idx63_y1", rd_y1, 16'd64);
        chk("c1_idx63_color", rd_color, 16'd63);
        repeat (3) cyc(1'b0, 16'($urandom), 6'($urandom));

        // Copy 2: colors 0xAAAA, a saturating rect at index 7, rd_idx held
        // at 0, a stray copy_start mid-copy and another on the swap edge.
        fill_random(1'b1);
        pkt[42] = 16'h0;    pkt[43] = 16'hFFF0; pkt[44] = 16'd5;
        pkt[45] = 16'h0020; pkt[46] = 16'h0;    pkt[47] = 16'hAAAA;
        run_copy(1'b1, 150, 1'b1, -1);
        cyc(1'b0, 16'h0, 6'd0);
        cyc(1'b0, 16'h0, 6'd7);
        @(negedge clk);
        chk("sat_x1", rd_x1, 16'hFFFF);
        chk("sat_y1", rd_y1, 16'd5);
        chk("sat_color", rd_color, 16'hAAAA);
        repeat (3) cyc(1'b0, 16'($urandom), 6'($urandom));

        // Copy 3 aborted by reset, then a clean copy.
        fill_random(1'b0);
        run_copy(1'b0, -1, 1'b0, 100);
        repeat (5) cyc(1'b0, 16'($urandom), 6'($urandom));
        fill_random(1'b0);
        run_copy(1'b0, -1, 1'b0, -1);
        repeat (3) cyc(1'b0, 16'($urandom), 6'($urandom));

        // copy_start held high: back-to-back copies.
        b2b = 1'b1;
        repeat (3 * 385 + 5) cyc(1'b1, 16'($urandom), 6'($urandom));
        b2b = 1'b0;
        repeat (400) cyc(1'b0, 16'($urandom), 6'($urandom));

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
